// File: rtl/dmem_responder.sv
// Word-addressed data memory responder for the core's dm_* port, with
// configurable wait states. Define DMEM_MISALIGN_ERR_EN to flag misaligned accesses.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic        wen_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] din_i,
  output logic [31:0] dout_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t             state;
  logic [3:0]         cnt;
  logic               lat_wen;
  logic [IDX_W-1:0]   lat_idx;
  logic [31:0]        lat_din;
  logic [1:0]         lat_lo;

  logic [31:0]        mem [DEPTH_WORDS];

  logic               accept;
  logic               fire;
  logic               acc_wen;
  logic               acc_bad;
  logic [IDX_W-1:0]   acc_idx;
  logic [31:0]        acc_din;
  logic [1:0]         acc_lo;

  assign accept = en_i && (state == S_IDLE);

  // With no wait states the access happens on the accepting edge using live
  // inputs; otherwise it replays the request latched at acceptance.
  always_comb begin
    fire    = 1'b0;
    acc_wen = 1'b0;
    acc_idx = '0;
    acc_din = '0;
    acc_lo  = '0;
    if (WAIT_CYCLES == 0) begin
      fire    = accept;
      acc_wen = wen_i;
      acc_idx = addr_i[IDX_W+1:2];
      acc_din = din_i;
      acc_lo  = addr_i[1:0];
    end else begin
      fire    = (state == S_WAIT) && (cnt == 4'd1);
      acc_wen = lat_wen;
      acc_idx = lat_idx;
      acc_din = lat_din;
      acc_lo  = lat_lo;
    end
  end

`ifdef DMEM_MISALIGN_ERR_EN
  assign acc_bad = (acc_lo != 2'b00);
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, addr_i[31:IDX_W+2]};
`else
  assign acc_bad = 1'b0;
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, addr_i[31:IDX_W+2], acc_lo};
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      busy_o  <= 1'b0;
      dout_o  <= 32'h0;
      err_o   <= 1'b0;
      lat_wen <= 1'b0;
      lat_idx <= '0;
      lat_din <= 32'h0;
      lat_lo  <= 2'b00;
    end else begin
      err_o <= fire && acc_bad;
      case (state)
        S_IDLE: begin
          if (accept && (WAIT_CYCLES != 0)) begin
            state   <= S_WAIT;
            cnt     <= WAIT_LOAD;
            busy_o  <= 1'b1;
            lat_wen <= wen_i;
            lat_idx <= addr_i[IDX_W+1:2];
            lat_din <= din_i;
            lat_lo  <= addr_i[1:0];
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
      endcase
      if (fire && !acc_wen) begin
        dout_o <= acc_bad ? 32'h0 : mem[acc_idx];
      end
    end
  end

  // Storage is deliberately not reset; the rst_n_i term keeps a zero-wait
  // request from committing while reset is held.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && fire && acc_wen && !acc_bad) begin
      mem[acc_idx] <= acc_din;
    end
  end

endmodule
